lsu_ctrl: RTL

Load/store sequencer between the single-cycle core datapath and a data memory with a valid/ready request port and a variable-latency read response. When the control unit flags a memory instruction, it stalls the PC, issues one byte-enabled request, and waits for acceptance (store) or read data (load). Loaded data is returned aligned and sign- or zero-extended for register writeback. It turns the single-cycle datapath into a stall-tolerant design without changing the control unit's decode.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_ld_ext.sv | 26 ++
 rtl/lsu_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states,
// access-size mask encodings and the alignment/legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Legal means a known size code whose bytes all fall inside one word.
    function automatic logic lsu_align_chk(input logic [1:0] off, input logic [3:0] mask);
        logic legal;
        case (mask)
            MASK_B:  legal = 1'b1;
            MASK_H:  legal = ~off[0];
            MASK_W:  legal = (off == 2'b00);
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_ld_ext.sv
// Load data extraction: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them according to the access size.
module lsu_ld_ext
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_mask,
    input  logic        i_un,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    assign w_shift = i_word >> {i_off, 3'b000};

    always_comb begin
        o_data = w_shift;
        case (i_mask)
            MASK_B:  o_data = {{24{w_shift[7] & ~i_un}}, w_shift[7:0]};
            MASK_H:  o_data = {{16{w_shift[15] & ~i_un}}, w_shift[15:0]};
            default: o_data = w_shift;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: stalls the single-cycle core while one byte-enabled
// memory request is issued and, for loads, the read response is awaited.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ld,
    input  logic        i_st,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_mask,
    input  logic        i_mem_un,
    output logic        o_stall,
    output logic        o_req,
    input  logic        i_ready,
    output logic        o_we,
    output logic [31:0] o_addr,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic        i_rvalid,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data,
    output logic        o_ld_vld,
    output logic        o_err,
    output lsu_state_e  o_dbg_state
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Request port: o_req holds with fixed we/addr/be/wdata until the cycle
    // where o_req & i_ready are both high; that cycle is the only transfer.
    lsu_state_e  r_state, w_next;
    logic        r_we, r_un, r_to, r_ld_vld;
    logic [31:0] r_addr, r_wdata, r_ld_data;
    logic [3:0]  r_be, r_mask;
    logic [1:0]  r_off;
    logic [7:0]  r_cnt;
    logic        w_any, w_legal, w_start, w_bad, w_timeout;
    logic [31:0] w_ext;

    assign w_any   = i_ld | i_st;
    assign w_legal = lsu_align_chk(i_addr[1:0], i_mask) & ~(i_ld & i_st);
    assign w_start = (r_state == ST_IDLE) & w_any & w_legal;
    assign w_bad   = (r_state == ST_IDLE) & w_any & ~w_legal;

    // Completion in the same cycle as the last counted cycle wins over abort.
    assign w_timeout = (r_cnt == TO_LAST) &
                       (((r_state == ST_REQ) & ~i_ready) | ((r_state == ST_WAIT) & ~i_rvalid));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_stall = 1'b0;
        o_req   = 1'b0;
        o_err   = w_bad;
        case (r_state)
            ST_IDLE: begin
                o_stall = w_start;
                if (w_start) w_next = ST_REQ;
            end
            ST_REQ: begin
                o_stall = 1'b1;
                o_req   = 1'b1;
                if (i_ready)        w_next = r_we ? ST_DONE : ST_WAIT;
                else if (w_timeout) w_next = ST_DONE;
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (i_rvalid || w_timeout) w_next = ST_DONE;
            end
            ST_DONE: begin
                o_err  = r_to;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_off     <= '0;
            r_mask    <= '0;
            r_un      <= 1'b0;
            r_cnt     <= '0;
            r_to      <= 1'b0;
            r_ld_vld  <= 1'b0;
            r_ld_data <= '0;
        end else begin
            if (w_start) begin
                r_we    <= i_st;
                r_addr  <= {i_addr[31:2], 2'b00};
                r_be    <= i_mask << i_addr[1:0];
                r_wdata <= i_wdata << {i_addr[1:0], 3'b000};
                r_off   <= i_addr[1:0];
                r_mask  <= i_mask;
                r_un    <= i_mem_un;
                r_cnt   <= '0;
            end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // Result registers are live for exactly the DONE cycle that follows.
            r_to      <= w_timeout;
            r_ld_vld  <= (r_state == ST_WAIT) & i_rvalid;
            r_ld_data <= ((r_state == ST_WAIT) & i_rvalid) ? w_ext : 32'd0;
        end
    end

    lsu_ld_ext u_ld_ext (
        .i_word (i_rdata),
        .i_off  (r_off),
        .i_mask (r_mask),
        .i_un   (r_un),
        .o_data (w_ext)
    );

    assign o_we        = r_we;
    assign o_addr      = r_addr;
    assign o_be        = r_be;
    assign o_wdata     = r_wdata;
    assign o_ld_data   = r_ld_data;
    assign o_ld_vld    = r_ld_vld;
    assign o_dbg_state = r_state;

endmodule
